pause_dim_ctrl: RTL

- Parametrised pause and screen-dim controller between hps_io/joystick logic, the hiscore module and the game core/video path of the arcade emu wrappers.
- Merges a user pause toggle with NSRC external pause requests (hiscore access, OSD-open, ...).
- Optionally aligns user pause to the vblank edge.
- After a timeout it fades the RGB output in stepped per-channel right shifts, and supports auto-unpause on coin/start.

---
 rtl/pause_dim_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pause_dim_ctrl.sv
// Pause/dim controller: merges a user pause toggle with external pause requests,
// then fades the RGB output in per-channel shift steps after a long user pause.
module pause_dim_ctrl #(
  parameter int              NSRC        = 2,
  parameter logic [NSRC-1:0] IMM_MASK    = '1,
  parameter bit              VB_SYNC     = 1'b1,
  parameter logic [31:0]     DIM_CYCLES  = 32'h1C9C3800,
  parameter int              DIM_STEPS   = 2,
  parameter int              STEP_FRAMES = 8,
  parameter int              RW          = 3,
  parameter int              GW          = 3,
  parameter int              BW          = 2,
  localparam int             DLW         = $clog2(DIM_STEPS + 1),
  localparam int             PW          = RW + GW + BW
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic            pause_btn,
  input  logic            unpause_btn,
  input  logic [NSRC-1:0] req,
  input  logic            vblank,
  input  logic [PW-1:0]   rgb_in,
  output logic [PW-1:0]   rgb_out,
  output logic            pause_n,
  output logic            user_paused,
  output logic [DLW-1:0]  dim_level
);

  localparam int             FW         = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [FW-1:0]  LAST_FRAME = FW'(STEP_FRAMES - 1);
  localparam logic [DLW-1:0] MAX_DIM    = DLW'(DIM_STEPS);

  logic           pause_prev_q, unpause_prev_q, vblank_prev_q;
  logic           user_req_q, user_req_d;
  logic           paused_q, paused_d;
  logic [31:0]    timer_q, timer_d;
  logic [DLW-1:0] dim_q, dim_d;
  logic [FW-1:0]  frame_q, frame_d;
  logic [PW-1:0]  rgb_q, rgb_d;

  logic pause_rise, unpause_rise, vb_rise;
  logic imm_req, sync_req;
  logic [RW-1:0] r_dim;
  logic [GW-1:0] g_dim;
  logic [BW-1:0] b_dim;

  assign pause_rise   = pause_btn & ~pause_prev_q;
  assign unpause_rise = unpause_btn & ~unpause_prev_q;
  assign vb_rise      = vblank & ~vblank_prev_q;

  // The user request joins whichever group VB_SYNC selects.
  assign imm_req  = (|(req & IMM_MASK))  | (~VB_SYNC & user_req_q);
  assign sync_req = (|(req & ~IMM_MASK)) | (VB_SYNC & user_req_q);

  assign r_dim = rgb_in[RW-1:0] >> dim_q;
  assign g_dim = rgb_in[RW +: GW] >> dim_q;
  assign b_dim = rgb_in[RW+GW +: BW] >> dim_q;

  always_comb begin
    user_req_d = user_req_q;
    paused_d   = 1'b0;
    timer_d    = timer_q;
    dim_d      = dim_q;
    frame_d    = frame_q;
    rgb_d      = {b_dim, g_dim, r_dim};

    // A pause press wins over a simultaneous coin/start press.
    if (pause_rise) begin
      user_req_d = ~user_req_q;
    end else if (unpause_rise) begin
      user_req_d = 1'b0;
    end

    if (imm_req) begin
      paused_d = 1'b1;
    end else if (sync_req) begin
      paused_d = paused_q | vb_rise;
    end

    if (!user_req_q) begin
      timer_d = '0;
    end else if (paused_q && (timer_q < DIM_CYCLES)) begin
      timer_d = timer_q + 32'd1;
    end

    if (!user_req_q) begin
      dim_d   = '0;
      frame_d = '0;
    end else if ((timer_q == DIM_CYCLES) && vb_rise) begin
      if (frame_q == LAST_FRAME) begin
        frame_d = '0;
        if (dim_q < MAX_DIM) dim_d = dim_q + DLW'(1);
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pause_prev_q   <= 1'b0;
      unpause_prev_q <= 1'b0;
      vblank_prev_q  <= 1'b0;
      user_req_q     <= 1'b0;
      paused_q       <= 1'b0;
      timer_q        <= '0;
      dim_q          <= '0;
      frame_q        <= '0;
      rgb_q          <= '0;
    end else begin
      pause_prev_q   <= pause_btn;
      unpause_prev_q <= unpause_btn;
      vblank_prev_q  <= vblank;
      user_req_q     <= user_req_d;
      paused_q       <= paused_d;
      timer_q        <= timer_d;
      dim_q          <= dim_d;
      frame_q        <= frame_d;
      rgb_q          <= rgb_d;
    end
  end

  assign rgb_out     = rgb_q;
  assign pause_n     = ~paused_q;
  assign user_paused = user_req_q;
  assign dim_level   = dim_q;

endmodule
